// File: rtl/tictactoe_pkg.sv
// Shared codes, state encoding and win/draw helpers for the tic-tac-toe controller.
// Latency: combinational helpers only; nothing here holds state.
// Backpressure: none; the package has no handshakes.
package tictactoe_pkg;

  // Cell codes shown on a1..a9; X and O double as the winner codes for a line
  localparam logic [1:0] EMPTY  = 2'b00;
  localparam logic [1:0] X      = 2'b01;
  localparam logic [1:0] O      = 2'b10;
  localparam logic [1:0] CURSOR = 2'b11;

  // Winner codes
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Button slots in the edge-detect vector
  localparam int NUM_BTN   = 6;
  localparam int BTN_START = 0;
  localparam int BTN_UP    = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 3;
  localparam int BTN_RIGHT = 4;
  localparam int BTN_PLACE = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    WIN  = 2'b10,
    DRAW = 2'b11
  } state_t;

  // Board, index 0 = top-left cell (a1), row-major
  typedef logic [8:0][1:0] board_t;

  // Owner of three cells when they form a line, else WIN_NONE
  function automatic logic [1:0] trio(input logic [1:0] p, input logic [1:0] q,
                                      input logic [1:0] r);
    return (p != EMPTY && p == q && p == r) ? p : WIN_NONE;
  endfunction

  // Owner of the first completed line; only one player can hold a line because
  // the game freezes on the cycle after any winning write
  function automatic logic [1:0] line_owner(input board_t b);
    logic [1:0] owner;
    owner = WIN_NONE;
    if      (trio(b[0], b[1], b[2]) != WIN_NONE) owner = b[0];
    else if (trio(b[3], b[4], b[5]) != WIN_NONE) owner = b[3];
    else if (trio(b[6], b[7], b[8]) != WIN_NONE) owner = b[6];
    else if (trio(b[0], b[3], b[6]) != WIN_NONE) owner = b[0];
    else if (trio(b[1], b[4], b[7]) != WIN_NONE) owner = b[1];
    else if (trio(b[2], b[5], b[8]) != WIN_NONE) owner = b[2];
    else if (trio(b[0], b[4], b[8]) != WIN_NONE) owner = b[0];
    else if (trio(b[2], b[4], b[6]) != WIN_NONE) owner = b[2];
    return owner;
  endfunction

  // True when no cell is empty
  function automatic logic board_full(input board_t b);
    logic full;
    full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (b[i] == EMPTY) full = 1'b0;
    end
    return full;
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for one debounced, level-type button.
// Latency: rise is combinational from level and a one-cycle history register.
// Backpressure: none; a held button yields a single one-cycle pulse.
module btn_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;

  // Remember last cycle's level; reset clears the history
  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/tictactoe_game_ctrl.sv
// Tic-tac-toe game controller: cursor, placement, win/draw detection; optional blink via CURSOR_BLINK_EN.
// Latency: a cell/cursor change appears one cycle after the edge-detect cycle; win/draw one cycle after the write.
// Backpressure: none; buttons are level inputs sampled every cycle, outputs are always valid.
module tictactoe_game_ctrl
  import tictactoe_pkg::*;
#(
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic       pixel_clock,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_place,
  output logic       start,
  output logic [1:0] a1,
  output logic [1:0] a2,
  output logic [1:0] a3,
  output logic [1:0] a4,
  output logic [1:0] a5,
  output logic [1:0] a6,
  output logic [1:0] a7,
  output logic [1:0] a8,
  output logic [1:0] a9,
  output logic       turn,
  output logic [1:0] winner
);

  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_rise;

  assign btn_level = {btn_place, btn_right, btn_left, btn_down, btn_up, btn_start};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_edge
    btn_edge_detect u_edge (
      .clk   (pixel_clock),
      .reset (reset),
      .level (btn_level[g]),
      .rise  (btn_rise[g])
    );
  end

  state_t     state, nxt_state;
  board_t     board, nxt_board, disp;
  logic [1:0] row, col, nxt_row, nxt_col;
  logic [3:0] cur_idx, nxt_cur_idx;
  logic       nxt_turn;
  logic [1:0] nxt_winner;
  logic [1:0] line_win;
  logic       full;
  logic       cursor_show;

  assign cur_idx     = {1'b0, row, 1'b0} + {2'b00, row} + {2'b00, col};
  assign nxt_cur_idx = {1'b0, nxt_row, 1'b0} + {2'b00, nxt_row} + {2'b00, nxt_col};
  assign line_win    = line_owner(board);
  assign full        = board_full(board);

  // Game rules: next board, cursor, turn, winner and state from current state and button edges
  always_comb begin
    nxt_state  = state;
    nxt_board  = board;
    nxt_row    = row;
    nxt_col    = col;
    nxt_turn   = turn;
    nxt_winner = winner;
    case (state)
      IDLE: begin
        if (btn_rise[BTN_START]) begin
          nxt_state  = PLAY;
          nxt_board  = '0;
          nxt_row    = 2'd1;
          nxt_col    = 2'd1;
          nxt_turn   = 1'b0;
          nxt_winner = WIN_NONE;
        end
      end
      PLAY: begin
        // A line or full board seen on the registered board ends the game before any button acts
        if (line_win != WIN_NONE) begin
          nxt_state  = WIN;
          nxt_winner = line_win;
        end else if (full) begin
          nxt_state  = DRAW;
          nxt_winner = WIN_DRAW;
        end else if (btn_rise[BTN_PLACE]) begin
          if (board[cur_idx] == EMPTY) begin
            nxt_board[cur_idx] = turn ? O : X;
            nxt_turn           = ~turn;
          end
        end else if (btn_rise[BTN_UP]) begin
          nxt_row = (row == 2'd0) ? 2'd2 : row - 2'd1;
        end else if (btn_rise[BTN_DOWN]) begin
          nxt_row = (row == 2'd2) ? 2'd0 : row + 2'd1;
        end else if (btn_rise[BTN_LEFT]) begin
          nxt_col = (col == 2'd0) ? 2'd2 : col - 2'd1;
        end else if (btn_rise[BTN_RIGHT]) begin
          nxt_col = (col == 2'd2) ? 2'd0 : col + 2'd1;
        end
      end
      WIN, DRAW: begin
        // Cursor position is kept across a rematch
        if (btn_rise[BTN_START]) begin
          nxt_state  = PLAY;
          nxt_board  = '0;
          nxt_turn   = 1'b0;
          nxt_winner = WIN_NONE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

`ifdef CURSOR_BLINK_EN
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [BLINK_W-1:0] blink_cnt, nxt_blink_cnt;
  logic               blink_on;
  logic               cursor_restart;

  // Every move changes the cursor position (wrap is modulo 3); entering play also restarts
  assign cursor_restart = (nxt_state == PLAY && state != PLAY) ||
                          (nxt_row != row) || (nxt_col != col);

  // Blink phase: restart shown on a move, otherwise flip every BLINK_CYCLES cycles
  always_comb begin
    nxt_blink_cnt = blink_cnt + 1'b1;
    cursor_show   = blink_on;
    if (cursor_restart) begin
      nxt_blink_cnt = '0;
      cursor_show   = 1'b1;
    end else if (blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
      nxt_blink_cnt = '0;
      cursor_show   = ~blink_on;
    end
  end

  // Blink counter and phase registers
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      blink_cnt <= nxt_blink_cnt;
      blink_on  <= cursor_show;
    end
  end
`else
  assign cursor_show = 1'b1;
`endif

  // Display image of the next board: cursor code only on an empty cell while playing
  always_comb begin
    disp = nxt_board;
    for (int i = 0; i < 9; i++) begin
      if (nxt_state == PLAY && cursor_show && nxt_cur_idx == 4'(i) &&
          nxt_board[i] == EMPTY) begin
        disp[i] = CURSOR;
      end
    end
  end

  // FSM state, board, cursor and all registered outputs
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state  <= IDLE;
      board  <= '0;
      row    <= 2'd1;
      col    <= 2'd1;
      turn   <= 1'b0;
      winner <= WIN_NONE;
      start  <= 1'b0;
      a1     <= EMPTY;
      a2     <= EMPTY;
      a3     <= EMPTY;
      a4     <= EMPTY;
      a5     <= EMPTY;
      a6     <= EMPTY;
      a7     <= EMPTY;
      a8     <= EMPTY;
      a9     <= EMPTY;
    end else begin
      state  <= nxt_state;
      board  <= nxt_board;
      row    <= nxt_row;
      col    <= nxt_col;
      turn   <= nxt_turn;
      winner <= nxt_winner;
      start  <= (nxt_state != IDLE);
      a1     <= disp[0];
      a2     <= disp[1];
      a3     <= disp[2];
      a4     <= disp[3];
      a5     <= disp[4];
      a6     <= disp[5];
      a7     <= disp[6];
      a8     <= disp[7];
      a9     <= disp[8];
    end
  end

endmodule
